depressurizer: RTL and testbench
================================

DEPRESSURIZER -- requirements
Module: depressurizer

Interface
REQ-001 Parameter PUMP_CYCLES, default 12'd2880, clock cycles of active venting (8 minutes at the system clock).
REQ-002 Parameter SETTLE_CYCLES, default 12'd30, clock cycles of valve-closed settling after venting.
REQ-003 clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high; forces the Reset state immediately.
REQ-005 start  input  1  request to depressurize the interlock chamber; level, sampled via a one-cycle input register.
REQ-006 abort  input  1  operator abort; sampled directly, not registered.
REQ-007 doorsClosed  input  1  high when both chamber doors are closed and sealed.
REQ-008 depressurizing  output  1  vent valve open; high only in PUMP.
REQ-009 busy  output  1  high in PUMP and SETTLE.
REQ-010 done  output  1  one-cycle pulse on successful completion.
REQ-011 fault  output  1  high while in FAULT.
REQ-012 remaining  output  12  cycles of venting left; PUMP_CYCLES minus count in PUMP, 0 otherwise.

Function
REQ-013 States SHALL be IDLE, PUMP, SETTLE, DONE, FAULT; all outputs registered from state and counter.
REQ-014 start SHALL pass through a one-cycle register (startQ); start high at edge k makes startQ high after edge k.
REQ-015 IDLE->PUMP SHALL occur on the edge where startQ=1, doorsClosed=1, abort=0; counter cleared to 0; depressurizing high after edge k+1.
REQ-016 startQ=1 in IDLE with doorsClosed=0 SHALL be ignored (stay IDLE, no fault).
REQ-017 In PUMP the 12-bit counter SHALL increment once per cycle; depressurizing SHALL be high for exactly PUMP_CYCLES cycles, then PUMP->SETTLE with counter cleared.
REQ-018 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then ->DONE.
REQ-019 DONE SHALL last one cycle with done=1, busy=0, then ->IDLE.
REQ-020 In PUMP or SETTLE, abort=1 or doorsClosed=0 SHALL cause ->FAULT on that edge; depressurizing and busy drop after that edge.
REQ-021 Abort/door-open SHALL take priority over a same-cycle PUMP->SETTLE or SETTLE->DONE transition (no done pulse).
REQ-022 FAULT SHALL hold fault=1 until a cycle with abort=0, doorsClosed=1, startQ=0, then ->IDLE.
REQ-023 start while busy SHALL be ignored; a held-high start SHALL NOT retrigger until it has been seen low in IDLE (rising-level rearm).
REQ-024 start and abort both high in IDLE SHALL leave the block in IDLE.
REQ-025 Counter SHALL never wrap; comparisons use PUMP_CYCLES-1 and SETTLE_CYCLES-1 as terminal values.

Reset
REQ-026 On reset: state IDLE, counter 0, startQ 0, rearm flag set; depressurizing, busy, done, fault 0; remaining 0.
REQ-027 Reset asserted mid-PUMP SHALL close the valve asynchronously with no done or fault pulse.
REQ-028 First transition after reset release requires a fresh startQ=1 sample.

Structure
REQ-029 State encodings and default cycle constants SHALL live in shared package interlock_pkg, also used by the pressurizer.
REQ-030 The 12-bit counter SHALL be a separate sub-module cycle_counter (clear, enable, count) reusable by pressurize/depressurize paths.
REQ-031 The input register SHALL reuse the existing one-cycle signal register block.

Verification (PUMP_CYCLES=10, SETTLE_CYCLES=3)
REQ-032 Nominal: doorsClosed=1, start pulse 1 cycle -> depressurizing high 10 cycles from edge k+1, busy 13 cycles, done pulse 1 cycle, remaining 10..1.
REQ-033 Doors open: doorsClosed=0, start pulse -> no busy, no fault, stays IDLE.
REQ-034 Abort at PUMP cycle 4 -> fault=1 next edge, depressurizing=0, remaining=0; release abort, start low -> IDLE one cycle later.
REQ-035 Door opens on final SETTLE cycle -> FAULT, done never asserts.
REQ-036 start held high through completion -> exactly one cycle run; second run only after start low then high.
REQ-037 Reset asserted mid-PUMP between edges -> depressurizing falls immediately, all outputs 0, IDLE after release.

Source files
------------

// File: rtl/interlock_pkg.sv
// Shared interlock definitions: chamber sequencing states and default cycle budgets.
// Used by both the pressurize and depressurize sequencers.
package interlock_pkg;

  localparam int CNT_W = 12;

  typedef logic [CNT_W-1:0] count_t;

  localparam count_t DEF_PUMP_CYCLES   = 12'd2880;
  localparam count_t DEF_SETTLE_CYCLES = 12'd30;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUMP,
    ST_SETTLE,
    ST_DONE,
    ST_FAULT
  } state_t;

endpackage

// File: rtl/depressurizer_if.sv
// Operator/chamber signal bundle for the depressurize sequencer.
interface depressurizer_if;
  import interlock_pkg::*;

  logic   start;
  logic   abort;
  logic   doorsClosed;
  logic   depressurizing;
  logic   busy;
  logic   done;
  logic   fault;
  count_t remaining;

  modport master (
    output start, abort, doorsClosed,
    input  depressurizing, busy, done, fault, remaining
  );

  modport slave (
    input  start, abort, doorsClosed,
    output depressurizing, busy, done, fault, remaining
  );

endinterface

// File: rtl/cycle_counter.sv
// Saturating 12-bit phase counter; clear wins over enable.
module cycle_counter
  import interlock_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   clear,
  input  logic   enable,
  output count_t count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                        count <= '0;
    else if (clear)                   count <= '0;
    else if (enable && count != '1)   count <= count + 12'd1;
  end

endmodule

// File: rtl/signal_reg.sv
// One-cycle input register with asynchronous clear, shared by the interlock blocks.
module signal_reg #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) q <= '0;
    else       q <= d;
  end

endmodule

// File: rtl/depressurizer.sv
// Interlock chamber depressurize sequencer: IDLE -> PUMP -> SETTLE -> DONE, with
// abort/door-open faulting and rising-level rearm of the start request.
module depressurizer
  import interlock_pkg::*;
#(
  parameter count_t PUMP_CYCLES   = DEF_PUMP_CYCLES,
  parameter count_t SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic            clock,
  input  logic            reset,
  depressurizer_if.slave  bus
);

  state_t state, state_next;
  count_t count;
  logic   startQ;
  logic   armed;
  logic   trigger;
  logic   hazard;
  logic   count_en;
  logic   count_clear;

  signal_reg #(.W(1)) u_start_reg (
    .clock (clock),
    .reset (reset),
    .d     (bus.start),
    .q     (startQ)
  );

  cycle_counter u_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (count_clear),
    .enable (count_en),
    .count  (count)
  );

  assign hazard      = bus.abort || !bus.doorsClosed;
  assign count_en    = (state == ST_PUMP) || (state == ST_SETTLE);
  // Every phase change restarts the count, so each phase measures from zero.
  assign count_clear = (state_next != state) || !count_en;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    trigger    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (startQ && armed && bus.doorsClosed && !bus.abort) begin
          trigger    = 1'b1;
          state_next = ST_PUMP;
        end
      end
      ST_PUMP: begin
        if (hazard)                             state_next = ST_FAULT;
        else if (count == PUMP_CYCLES - 12'd1)  state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (hazard)                             state_next = ST_FAULT;
        else if (count == SETTLE_CYCLES - 12'd1) state_next = ST_DONE;
      end
      ST_DONE:  state_next = ST_IDLE;
      ST_FAULT: if (!hazard && !startQ) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // A start held high across a run must be seen low in IDLE before it can fire again.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      armed <= 1'b1;
    end else begin
      state <= state_next;
      if (trigger)                          armed <= 1'b0;
      else if (state == ST_IDLE && !startQ) armed <= 1'b1;
    end
  end

  assign bus.depressurizing = (state == ST_PUMP);
  assign bus.busy           = (state == ST_PUMP) || (state == ST_SETTLE);
  assign bus.done           = (state == ST_DONE);
  assign bus.fault          = (state == ST_FAULT);
  assign bus.remaining      = (state == ST_PUMP) ? PUMP_CYCLES - count : '0;

endmodule

// File: tb/tb_depressurizer.sv
// Self-checking bench for depressurizer with PUMP_CYCLES=10, SETTLE_CYCLES=3.
module tb_depressurizer;
  import interlock_pkg::*;

  localparam int P = 10;
  localparam int S = 3;
  localparam logic [15:0] IDLE_V  = 16'h0000;
  localparam logic [15:0] FAULT_V = 16'h1000;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  depressurizer_if bus();

  depressurizer #(.PUMP_CYCLES(12'd10), .SETTLE_CYCLES(12'd3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Observation vector: {depressurizing, busy, done, fault, remaining[11:0]}
  function automatic logic [15:0] pack(bit dep, bit bsy, bit dn, bit flt, int rem);
    return {dep, bsy, dn, flt, 12'(rem)};
  endfunction

  function automatic logic [15:0] observe();
    return {bus.depressurizing, bus.busy, bus.done, bus.fault, bus.remaining};
  endfunction

  // Expected outputs i cycles after the edge on which start was registered.
  function automatic logic [15:0] run_at(int i);
    bit dep = (i >= 1 && i <= P);
    bit bsy = (i >= 1 && i <= P + S);
    bit dn  = (i == P + S + 1);
    return pack(dep, bsy, dn, 1'b0, dep ? (P + 1 - i) : 0);
  endfunction

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    logic [15:0] got;
    reset = 1'b1;
    step();
    got = observe(); checks++;
    if (got !== IDLE_V) begin errors++; $display("FAIL reset_hold got %h want %h", got, IDLE_V); end
    reset = 1'b0;
    step();
    got = observe(); checks++;
    if (got !== IDLE_V) begin errors++; $display("FAIL reset_release got %h want %h", got, IDLE_V); end
  endtask

  task automatic test_nominal(int gap);
    logic [15:0] got, exp;
    repeat (gap) step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i <= P + S + 3; i++) begin
      if (i > 0) step();
      got = observe(); exp = run_at(i); checks++;
      if (got !== exp) begin errors++; $display("FAIL nominal[%0d] got %h want %h", i, got, exp); end
    end
  endtask

  task automatic test_doors_open(int width);
    logic [15:0] got;
    bus.doorsClosed = 1'b0;
    bus.start = 1'b1;
    repeat (width) step();
    bus.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      got = observe(); checks++;
      if (got !== IDLE_V) begin errors++; $display("FAIL doors_open[%0d] got %h want %h", i, got, IDLE_V); end
    end
    bus.doorsClosed = 1'b1;
    step();
    got = observe(); checks++;
    if (got !== IDLE_V) begin errors++; $display("FAIL doors_reclosed got %h want %h", got, IDLE_V); end
  endtask

  // Hazard raised during run cycle 'at' (1..P+S); the next edge must enter FAULT.
  task automatic test_fault(int at, bit use_door);
    int hold = $urandom_range(1, 3);
    logic [15:0] got, exp;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i <= at; i++) begin
      if (i > 0) step();
      got = observe(); exp = run_at(i); checks++;
      if (got !== exp) begin errors++; $display("FAIL fault_run[%0d] got %h want %h", i, got, exp); end
    end
    if (use_door) bus.doorsClosed = 1'b0;
    else          bus.abort = 1'b1;
    for (int h = 0; h < hold; h++) begin
      step();
      got = observe(); checks++;
      if (got !== FAULT_V) begin errors++; $display("FAIL fault_hold[at=%0d,%0d] got %h want %h", at, h, got, FAULT_V); end
    end
    bus.abort = 1'b0;
    bus.doorsClosed = 1'b1;
    step();
    got = observe(); checks++;
    if (got !== IDLE_V) begin errors++; $display("FAIL fault_exit[at=%0d] got %h want %h", at, got, IDLE_V); end
  endtask

  task automatic test_fault_start_blocks();
    logic [15:0] got;
    logic [15:0] exp_seq [4] = '{FAULT_V, FAULT_V, FAULT_V, IDLE_V};
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (3) step();
    bus.abort = 1'b1;
    step();
    bus.start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) bus.abort = 1'b0;
      if (i == 2) bus.start = 1'b0;
      step();
      got = observe(); checks++;
      if (got !== exp_seq[i]) begin errors++; $display("FAIL fault_start_block[%0d] got %h want %h", i, got, exp_seq[i]); end
    end
  endtask

  task automatic test_held_start(int low_gap);
    logic [15:0] got, exp;
    bus.start = 1'b1;
    step();
    for (int i = 0; i <= P + S + 5; i++) begin
      if (i > 0) step();
      got = observe(); exp = run_at(i); checks++;
      if (got !== exp) begin errors++; $display("FAIL held_first[%0d] got %h want %h", i, got, exp); end
    end
    bus.start = 1'b0;
    for (int i = 0; i < low_gap; i++) begin
      step();
      got = observe(); checks++;
      if (got !== IDLE_V) begin errors++; $display("FAIL held_low[%0d] got %h want %h", i, got, IDLE_V); end
    end
    bus.start = 1'b1;
    step();
    for (int i = 0; i <= P + S + 2; i++) begin
      if (i > 0) step();
      got = observe(); exp = run_at(i); checks++;
      if (got !== exp) begin errors++; $display("FAIL held_second[%0d] got %h want %h", i, got, exp); end
    end
    bus.start = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_start_abort_idle();
    logic [15:0] got;
    bus.abort = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    bus.abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      got = observe(); checks++;
      if (got !== IDLE_V) begin errors++; $display("FAIL start_abort_idle[%0d] got %h want %h", i, got, IDLE_V); end
      step();
    end
  endtask

  task automatic test_reset_mid_pump(int n);
    logic [15:0] got, exp;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (n) step();
    #2 reset = 1'b1;
    #1;
    got = observe(); checks++;
    if (got !== IDLE_V) begin errors++; $display("FAIL reset_async got %h want %h", got, IDLE_V); end
    bus.start = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    // Start held through reset still needs one fresh registered sample before PUMP.
    step();
    for (int i = 0; i <= P + S + 1; i++) begin
      if (i > 0) step();
      got = observe(); exp = run_at(i); checks++;
      if (got !== exp) begin errors++; $display("FAIL reset_fresh[%0d] got %h want %h", i, got, exp); end
    end
    bus.start = 1'b0;
    repeat (2) step();
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.doorsClosed = 1'b1;
    reset = 1'b1;

    test_reset();
    test_nominal(0);
    test_doors_open(1);
    test_fault(4, 1'b0);
    test_fault(P + S, 1'b1);
    test_fault(P, 1'b0);
    test_fault_start_blocks();
    test_held_start(1);
    test_start_abort_idle();
    test_reset_mid_pump(5);

    for (int it = 0; it < 12; it++) begin
      case ($urandom_range(0, 3))
        0:       test_nominal($urandom_range(0, 3));
        1:       test_fault($urandom_range(1, P + S), 1'($urandom_range(0, 1)));
        2:       test_held_start($urandom_range(1, 3));
        default: test_doors_open($urandom_range(1, 3));
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule
